// File: rtl/io_halfduplex_master.sv
// Half-duplex master: 8-bit request out over a strobe plus 2-bit bus, turnaround, 8-bit response back.
// Optional parity beat in each direction when IO_HALFDUPLEX_PARITY_EN is defined.
module io_halfduplex_master #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned RX_TIMEOUT  = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  inout  wire        io1,
  inout  wire  [1:0] io2
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TX   = 3'd1,
    TURN = 3'd2,
    RX   = 3'd3,
    DONE = 3'd4
  } state_t;

`ifdef IO_HALFDUPLEX_PARITY_EN
  localparam logic [2:0] LAST_BEAT = 3'd4;
`else
  localparam logic [2:0] LAST_BEAT = 3'd3;
`endif
  localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_C  = 8'(RX_TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] beat_q, beat_d;
  logic [3:0] turn_q, turn_d;
  logic [7:0] to_q, to_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [1:0] tx_beat_q, tx_beat_d;
  logic       oe_q, oe_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       busy_q, busy_d;
  logic       strobe;

  // Only a clean 1 is a strobe; a floating or unknown line is treated as idle.
  assign strobe = (io1 === 1'b1);

  function automatic logic [1:0] tx_slice(input logic [7:0] b, input logic [2:0] idx);
    case (idx)
      3'd0:    return b[7:6];
      3'd1:    return b[5:4];
      3'd2:    return b[3:2];
      3'd3:    return b[1:0];
`ifdef IO_HALFDUPLEX_PARITY_EN
      3'd4:    return {^b, 1'b0};
`endif
      default: return 2'b00;
    endcase
  endfunction

  // Left-justify a partially filled response so captured beats land in the high bits.
  function automatic logic [7:0] align_partial(input logic [7:0] sh, input logic [2:0] n);
    case (n)
      3'd0:    return 8'h00;
      3'd1:    return {sh[1:0], 6'b0};
      3'd2:    return {sh[3:0], 4'b0};
      3'd3:    return {sh[5:0], 2'b0};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    turn_d      = turn_q;
    to_d        = to_q;
    tx_byte_d   = tx_byte_q;
    tx_beat_d   = tx_beat_q;
    oe_d        = oe_q;
    sh_d        = sh_q;
    rx_cnt_d    = rx_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          tx_byte_d = req_data;
          beat_d    = 3'd0;
          tx_beat_d = tx_slice(req_data, 3'd0);
          oe_d      = 1'b1;
          state_d   = TX;
        end
      end
      TX: begin
        if (beat_q == LAST_BEAT) begin
          oe_d    = 1'b0;
          turn_d  = 4'd0;
          state_d = TURN;
        end else begin
          beat_d    = beat_q + 3'd1;
          tx_beat_d = tx_slice(tx_byte_q, beat_q + 3'd1);
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          rx_cnt_d = 3'd0;
          to_d     = 8'd0;
          sh_d     = 8'd0;
          state_d  = RX;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      RX: begin
        if (strobe) begin
          to_d = 8'd0;
`ifdef IO_HALFDUPLEX_PARITY_EN
          if (rx_cnt_q == LAST_BEAT) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sh_q;
            rsp_err_d   = io2[1] ^ (^sh_q);
            state_d     = DONE;
          end else begin
            sh_d     = {sh_q[5:0], io2};
            rx_cnt_d = rx_cnt_q + 3'd1;
          end
`else
          sh_d     = {sh_q[5:0], io2};
          rx_cnt_d = rx_cnt_q + 3'd1;
          if (rx_cnt_q == LAST_BEAT) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = {sh_q[5:0], io2};
            rsp_err_d   = 1'b0;
            state_d     = DONE;
          end
`endif
        end else begin
          to_d = (to_q == 8'hFF) ? to_q : to_q + 8'd1;
          if (to_d >= TIMEOUT_C) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = align_partial(sh_q, rx_cnt_q);
            rsp_err_d   = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        oe_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= 3'd0;
      turn_q      <= 4'd0;
      to_q        <= 8'd0;
      tx_byte_q   <= 8'd0;
      tx_beat_q   <= 2'd0;
      oe_q        <= 1'b0;
      sh_q        <= 8'd0;
      rx_cnt_q    <= 3'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      turn_q      <= turn_d;
      to_q        <= to_d;
      tx_byte_q   <= tx_byte_d;
      tx_beat_q   <= tx_beat_d;
      oe_q        <= oe_d;
      sh_q        <= sh_d;
      rx_cnt_q    <= rx_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign io1       = oe_q ? 1'b1 : 1'bz;
  assign io2       = oe_q ? tx_beat_q : 2'bzz;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_io_halfduplex_master.sv
// Directed bench for io_halfduplex_master with a far-end driver on the shared lines.
// Released lines are pulled (io1 low, io2 high) so a released bus is observable as 0 / 2'b11.
module tb_io_halfduplex_master;

  localparam int TURN  = 2;
  localparam int RX_TO = 15;
`ifdef IO_HALFDUPLEX_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int LAT = NB + TURN + NB + 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_data;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  tri0        io1;
  tri1  [1:0] io2;

  logic       fe_oe  = 1'b0;
  logic       fe_io1 = 1'b0;
  logic [1:0] fe_io2 = 2'b00;

  assign io1 = fe_oe ? fe_io1 : 1'bz;
  assign io2 = fe_oe ? fe_io2 : 2'bzz;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  io_halfduplex_master #(.TURN_CYCLES(TURN), .RX_TIMEOUT(RX_TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .io1       (io1),
    .io2       (io2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clock);
    ncyc++;
  endtask

  function automatic logic [1:0] exp_beat(input logic [7:0] d, input int k);
    logic [7:0] s;
    if (k == 4) return {^d, 1'b0};
    s = d >> (6 - 2 * k);
    return s[1:0];
  endfunction

  // Called at a negedge with req_ready high; returns at the negedge of the last turnaround cycle.
  task automatic send_tx(input logic [7:0] d);
    req_valid = 1'b1;
    req_data  = d;
    @(posedge clock);
    ncyc = 0;
    for (int k = 0; k < NB; k++) begin
      nx();
      if (k == 0) req_data = ~d;
      check("tx_io1", io1, 1);
      check("tx_beat", io2, exp_beat(d, k));
      check("tx_busy", busy, 1);
      check("tx_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    for (int t = 0; t < TURN; t++) begin
      nx();
      check("turn_io1", io1, 0);
      check("turn_io2", io2, 2'b11);
    end
  endtask

  task automatic rx_beat(input logic [1:0] b);
    nx();
    fe_oe  = 1'b1;
    fe_io1 = 1'b1;
    fe_io2 = b;
  endtask

  task automatic rx_idle();
    nx();
    fe_oe  = 1'b1;
    fe_io1 = 1'b0;
    fe_io2 = 2'b00;
  endtask

  task automatic rx_byte(input logic [7:0] d, input int gap);
    logic [7:0] s;
    for (int k = 0; k < 4; k++) begin
      s = d >> (6 - 2 * k);
      rx_beat(s[1:0]);
      if (k < 3)
        for (int g = 0; g < gap; g++) rx_idle();
    end
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat, input logic [7:0] exp_data,
                          input logic exp_err);
    int lat;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      nx();
      fe_oe = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = ncyc;
        break;
      end
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_ready_in_done"}, req_ready, 0);
    check({tag, "_busy_in_done"}, busy, 1);
    $display("xfer %s: rsp_data=%h rsp_err=%b latency=%0d", tag, rsp_data, rsp_err, lat);
    nx();
    check({tag, "_valid_pulse"}, rsp_valid, 0);
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_data_held"}, rsp_data, exp_data);
    check({tag, "_err_held"}, rsp_err, exp_err);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_data  = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) nx();
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 8'h00);
    check("rst_err", rsp_err, 0);
    check("rst_io1", io1, 0);
    check("rst_io2", io2, 2'b11);

    // Back-to-back far end
    send_tx(8'hB4);
    rx_byte(8'h3C, 0);
`ifdef IO_HALFDUPLEX_PARITY_EN
    rx_beat({^(8'h3C), 1'b0});
`endif
    wait_rsp("b4_3c", LAT, 8'h3C, 1'b0);

    // Three idle cycles between response beats
    send_tx(8'h5E);
    rx_byte(8'hA5, 3);
`ifdef IO_HALFDUPLEX_PARITY_EN
    rx_beat({^(8'hA5), 1'b0});
`endif
    wait_rsp("gap_a5", LAT + 9, 8'hA5, 1'b0);

    // Two beats then silence: timeout, partial byte left-justified
    send_tx(8'h69);
    rx_beat(2'b11);
    rx_beat(2'b01);
    wait_rsp("timeout", NB + TURN + 2 + RX_TO + 1, 8'hD0, 1'b1);

    // Reset during the second TX beat
    req_valid = 1'b1;
    req_data  = 8'hC3;
    @(posedge clock);
    ncyc = 0;
    nx();
    req_valid = 1'b0;
    check("abort_beat0", io2, 2'b11);
    nx();
    check("abort_beat1", io2, 2'b00);
    check("abort_io1", io1, 1);
    reset = 1'b1;
    nx();
    reset = 1'b0;
    check("abort_io1_rel", io1, 0);
    check("abort_io2_rel", io2, 2'b11);
    check("abort_busy", busy, 0);
    check("abort_ready", req_ready, 1);
    check("abort_valid", rsp_valid, 0);
    check("abort_data", rsp_data, 8'h00);
    check("abort_err", rsp_err, 0);
    for (int i = 0; i < 3; i++) begin
      nx();
      check("abort_quiet_valid", rsp_valid, 0);
      check("abort_quiet_io1", io1, 0);
    end
    $display("xfer abort: reset during TX beat 2");

    send_tx(8'h01);
    rx_byte(8'h5A, 0);
`ifdef IO_HALFDUPLEX_PARITY_EN
    rx_beat({^(8'h5A), 1'b0});
`endif
    wait_rsp("after_abort", LAT, 8'h5A, 1'b0);

`ifdef IO_HALFDUPLEX_PARITY_EN
    send_tx(8'h07);
    rx_byte(8'hFF, 0);
    rx_beat(2'b10);
    wait_rsp("par_bad", LAT, 8'hFF, 1'b1);

    send_tx(8'h07);
    rx_byte(8'hFF, 0);
    rx_beat(2'b00);
    wait_rsp("par_good", LAT, 8'hFF, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
